i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_line_sync.sv | 30 +++
 rtl/i2c_slave.sv | 132 +++++++++++++
 tb/tb_i2c_slave.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding and sizing for the I2C slave.
package i2c_pkg;
    typedef logic [3:0] state_t;
    localparam state_t IDLE      = 4'd0;
    localparam state_t ADDR      = 4'd1;
    localparam state_t ADDR_ACK  = 4'd2;
    localparam state_t REG       = 4'd3;
    localparam state_t REG_ACK   = 4'd4;
    localparam state_t WDATA     = 4'd5;
    localparam state_t WDATA_ACK = 4'd6;
    localparam state_t RDATA     = 4'd7;
    localparam state_t RDATA_ACK = 4'd8;
    localparam state_t WAIT_STOP = 4'd9;
    localparam int NUM_BYTES = 4;
    localparam int RF_DEPTH  = 4;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-flop synchronizer with edge detect; I2C_SLAVE_GLITCH_FILTER_EN
// adds a 3-sample majority filter (one extra clk of latency).
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [1:0] sync;
    logic       prev;
    always_ff @(posedge clk or negedge rst)
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], din};
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] hist;
    always_ff @(posedge clk or negedge rst)
        if (!rst) hist <= 2'b11;
        else      hist <= {hist[0], sync[1]};
    assign level = (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
`else
    assign level = sync[1];
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) prev <= 1'b1;
        else      prev <= level;
    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C slave with a 4 x 32-bit register file, 4-byte write/read frames.
// Optional I2C_SLAVE_GLITCH_FILTER_EN enables line majority filtering.
module i2c_slave import i2c_pkg::*; #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_out,
    output logic [31:0] ext_data_out,
    output logic [7:0]  ext_reg_addr_out,
    output logic        wr_valid,
    output logic        busy
);
    logic        scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
    state_t      state;
    logic [31:0] sr, tx;
    logic [31:0] rf [RF_DEPTH];
    logic [3:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [7:0]  reg_addr;
    logic        rw, nack;
    i2c_line_sync u_scl (.clk(clk), .rst(rst), .din(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_line_sync u_sda (.clk(clk), .rst(rst), .din(sda_in), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));
    wire start = sda_fall & scl_lvl;
    wire stop  = sda_rise & scl_lvl;
    wire last  = byte_cnt == 2'(NUM_BYTES - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            sda_out          <= 1'b1;
            ext_data_out     <= '0;
            ext_reg_addr_out <= '0;
            wr_valid         <= 1'b0;
            busy             <= 1'b0;
            sr               <= '0;
            tx               <= '0;
            bit_cnt          <= '0;
            byte_cnt         <= '0;
            reg_addr         <= '0;
            rw               <= 1'b0;
            nack             <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (start) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_out <= 1'b1;
                busy    <= 1'b1;
            end else if (stop) begin
                state   <= IDLE;
                sda_out <= 1'b1;
                busy    <= 1'b0;
            end else begin
                if (scl_rise && (state == ADDR || state == REG || state == WDATA || state == RDATA)) begin
                    sr      <= {sr[30:0], sda_lvl};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (scl_rise && state == RDATA_ACK) nack <= sda_lvl;
                // all sda_out changes happen here, just after scl has gone low
                if (scl_fall) begin
                    case (state)
                        ADDR: if (bit_cnt == 4'd8) begin
                            if (sr[7:1] == SLAVE_ADDR) begin
                                state   <= ADDR_ACK;
                                sda_out <= 1'b0;
                                rw      <= sr[0];
                            end else state <= WAIT_STOP;
                        end
                        ADDR_ACK: begin
                            state   <= REG;
                            sda_out <= 1'b1;
                            bit_cnt <= '0;
                        end
                        REG: if (bit_cnt == 4'd8) begin
                            state    <= REG_ACK;
                            sda_out  <= 1'b0;
                            reg_addr <= sr[7:0];
                        end
                        REG_ACK: begin
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            state    <= rw ? RDATA : WDATA;
                            sda_out  <= rw ? rf[reg_addr[1:0]][31] : 1'b1;
                            tx       <= {rf[reg_addr[1:0]][30:0], 1'b0};
                        end
                        WDATA: if (bit_cnt == 4'd8) begin
                            state   <= WDATA_ACK;
                            sda_out <= 1'b0;
                        end
                        WDATA_ACK: begin
                            sda_out <= 1'b1;
                            bit_cnt <= '0;
                            if (last) begin
                                rf[reg_addr[1:0]] <= sr;
                                ext_data_out      <= sr;
                                ext_reg_addr_out  <= reg_addr;
                                wr_valid          <= 1'b1;
                                state             <= WAIT_STOP;
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                                state    <= WDATA;
                            end
                        end
                        RDATA: if (bit_cnt == 4'd8) begin
                            state   <= RDATA_ACK;
                            sda_out <= 1'b1;
                        end else begin
                            sda_out <= tx[31];
                            tx      <= {tx[30:0], 1'b0};
                        end
                        RDATA_ACK: begin
                            bit_cnt <= '0;
                            if (nack || last) begin
                                state   <= WAIT_STOP;
                                sda_out <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                                state    <= RDATA;
                                sda_out  <= tx[31];
                                tx       <= {tx[30:0], 1'b0};
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bus-master transactions against i2c_slave.
module tb_i2c_slave;
    localparam int Q = 10;
    logic        clk = 1'b0, rst = 1'b0, scl = 1'b1, m_sda = 1'b1;
    logic        sda_in, sda_out, wr_valid, busy;
    logic [31:0] ext_data_out;
    logic [7:0]  ext_reg_addr_out;
    int          n_cmp = 0, n_bad = 0, wr_cnt = 0;
    logic        ack;
    logic [7:0]  b;
    int          acks;
    logic [31:0] w;

    assign sda_in = m_sda & sda_out;
    always #5 clk = ~clk;
    always @(negedge clk) if (wr_valid) wr_cnt++;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in), .sda_out(sda_out),
        .ext_data_out(ext_data_out), .ext_reg_addr_out(ext_reg_addr_out),
        .wr_valid(wr_valid), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic gap();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_c();
        m_sda = 1'b1; gap(); scl = 1'b1; gap(); m_sda = 1'b0; gap(); scl = 1'b0; gap();
    endtask

    task automatic stop_c();
        m_sda = 1'b0; gap(); scl = 1'b1; gap(); m_sda = 1'b1; gap();
    endtask

    task automatic bit_x(input logic d, output logic r);
        m_sda = d; gap(); scl = 1'b1; gap(); r = sda_in; gap(); scl = 1'b0; gap();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic a);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(d[i], r);
        bit_x(1'b1, a);
    endtask

    task automatic rd_byte(input logic nk, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        bit_x(nk, r);
    endtask

    task automatic write_word(input logic [7:0] ra, input logic [31:0] d, output int n);
        logic a;
        n = 0;
        wr_byte(8'hA0, a); n += int'(!a);
        wr_byte(ra, a);    n += int'(!a);
        for (int k = 3; k >= 0; k--) begin
            wr_byte(d[8*k +: 8], a);
            n += int'(!a);
        end
    endtask

    task automatic read_word(input logic [7:0] ra, output logic [31:0] d);
        logic a;
        logic [7:0] x;
        start_c();
        wr_byte(8'hA1, a);
        wr_byte(ra, a);
        for (int k = 3; k >= 0; k--) begin
            rd_byte(1'b0, x);
            d[8*k +: 8] = x;
        end
        stop_c();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sda", sda_out, 1);
        check("rst_data", ext_data_out, 0);
        check("rst_reg", ext_reg_addr_out, 0);
        check("rst_wrv", wr_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        gap();

        start_c();
        check("start_busy", busy, 1);
        write_word(8'h02, 32'hDEADBEEF, acks);
        check("wr_acks", acks, 6);
        check("wr_pulses", wr_cnt, 1);
        check("wr_data", ext_data_out, 32'hDEADBEEF);
        check("wr_reg", ext_reg_addr_out, 8'h02);
        check("wr_busy", busy, 1);
        stop_c();
        check("stop_busy", busy, 0);

        read_word(8'h02, w);
        check("rd_word", w, 32'hDEADBEEF);
        check("rd_sda_rel", sda_out, 1);

        start_c();
        wr_byte(8'hA2, ack);
        check("bad_addr_ack", ack, 1);
        wr_byte(8'h00, ack);
        check("bad_addr_ack2", ack, 1);
        check("bad_addr_busy", busy, 1);
        stop_c();
        check("bad_addr_idle", busy, 0);
        check("bad_addr_wrv", wr_cnt, 1);

        start_c();
        wr_byte(8'hA0, ack);
        wr_byte(8'h01, ack);
        wr_byte(8'h11, ack);
        wr_byte(8'h22, ack);
        check("part_ack", ack, 0);
        stop_c();
        check("part_busy", busy, 0);
        check("part_wrv", wr_cnt, 1);
        check("part_keep", ext_data_out, 32'hDEADBEEF);
        read_word(8'h01, w);
        check("part_entry1", w, 0);

        start_c();
        wr_byte(8'hA1, ack);
        wr_byte(8'h02, ack);
        rd_byte(1'b1, b);
        check("nack_b1", b, 8'hDE);
        rd_byte(1'b0, b);
        check("nack_b2", b, 8'hFF);
        check("nack_busy", busy, 1);
        stop_c();
        check("nack_idle", busy, 0);

        start_c();
        wr_byte(8'hA0, ack);
        wr_byte(8'h03, ack);
        wr_byte(8'hAA, ack);
        wr_byte(8'hBB, ack);
        start_c();
        write_word(8'h03, 32'h12345678, acks);
        check("rs_acks", acks, 6);
        check("rs_pulses", wr_cnt, 2);
        check("rs_data", ext_data_out, 32'h12345678);
        check("rs_reg", ext_reg_addr_out, 8'h03);
        stop_c();

        start_c();
        wr_byte(8'hA0, ack);
        wr_byte(8'h00, ack);
        for (int i = 0; i < 8; i++) bit_x(1'b0, ack);
        m_sda = 1'b1; gap(); scl = 1'b1; gap();
        check("mid_ack_low", sda_out, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_sda", sda_out, 1);
        check("mid_rst_data", ext_data_out, 0);
        check("mid_rst_reg", ext_reg_addr_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wrv", wr_valid, 0);
        @(negedge clk) rst = 1'b1;
        gap(); scl = 1'b0; gap();
        wr_byte(8'h00, ack);
        check("post_rst_ignore", ack, 1);
        check("post_rst_busy", busy, 0);
        stop_c();
        check("post_rst_wrv", wr_cnt, 2);
        read_word(8'h02, w);
        check("post_rst_rf", w, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
